// File: rtl/arp_pkg.sv
// Shared widths, FSM state encodings and the table entry layout for the ARP resolver.
package arp_pkg;

  localparam int IP_W   = 32;
  localparam int MAC_W  = 48;
  localparam int PORT_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_DECIDE = 3'd2;
  localparam logic [2:0] ST_REQ    = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;

  typedef struct packed {
    logic              valid;
    logic [IP_W-1:0]   ip;
    logic [PORT_W-1:0] port;
    logic [MAC_W-1:0]  mac;
  } arp_entry_t;

  // Port numbers are 1-based; 0 and anything above the physical port count are invalid.
  function automatic logic port_ok(input logic [PORT_W-1:0] port, input int num_ports);
    return (port != '0) && (int'(port) <= num_ports);
  endfunction

endpackage

// File: rtl/arp_cam.sv
// Learned IP->MAC table: parallel key compare with registered result, reply learning
// with round-robin replacement, and flush.
module arp_cam
  import arp_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int NUM_PORTS = 8
) (
  input  logic              clk_net,
  input  logic              rst_n,
  input  logic [IP_W-1:0]   key_ip,
  input  logic [PORT_W-1:0] key_port,
  output logic              hit,
  output logic [MAC_W-1:0]  hit_mac,
  input  logic [IP_W-1:0]   rep_ip,
  input  logic [PORT_W-1:0] rep_port,
  input  logic [MAC_W-1:0]  rep_mac,
  input  logic              rep_en,
  input  logic              flush
);

  localparam int PTR_W = $clog2(ENTRIES);

  arp_entry_t         table_q [ENTRIES];
  logic [PTR_W-1:0]   wr_ptr;
  logic [ENTRIES-1:0] key_match;
  logic [ENTRIES-1:0] rep_match;
  logic               lk_hit;
  logic [MAC_W-1:0]   lk_mac;
  logic               rep_any;
  logic [PTR_W-1:0]   rep_idx;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      key_match[i] = table_q[i].valid && (table_q[i].ip == key_ip) && (table_q[i].port == key_port);
      rep_match[i] = table_q[i].valid && (table_q[i].ip == rep_ip) && (table_q[i].port == rep_port);
    end
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit  = 1'b0;
    lk_mac  = '0;
    rep_any = 1'b0;
    rep_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (key_match[i]) begin
        lk_hit = 1'b1;
        lk_mac = table_q[i].mac;
      end
      if (rep_match[i]) begin
        rep_any = 1'b1;
        rep_idx = PTR_W'(i);
      end
    end
  end

  // Flush takes precedence over a coincident reply, which then leaves the table untouched.
  always_ff @(posedge clk_net) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
      wr_ptr  <= '0;
      hit     <= 1'b0;
      hit_mac <= '0;
    end else begin
      hit     <= lk_hit;
      hit_mac <= lk_mac;
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          table_q[i].valid <= 1'b0;
        end
      end else if (rep_en && port_ok(rep_port, NUM_PORTS)) begin
        if (rep_any) begin
          table_q[rep_idx].mac <= rep_mac;
        end else begin
          table_q[wr_ptr] <= '{valid: 1'b1, ip: rep_ip, port: rep_port, mac: rep_mac};
          wr_ptr          <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arp_lookup_ctrl.sv
// ARP resolver for the net-side packet buffer: one query at a time, answered from the
// learned table or via ARP requests with timeout and retry.
module arp_lookup_ctrl
  import arp_pkg::*;
#(
  parameter int ENTRIES        = 16,
  parameter int NUM_PORTS      = 8,
  parameter int TIMEOUT_CYCLES = 125000,
  parameter int RETRIES        = 2
) (
  input  logic              clk_net,
  input  logic              rst_n,
  input  logic [IP_W-1:0]   arp_ip_din,
  input  logic [PORT_W-1:0] arp_port_num_din,
  input  logic              arp_din_en,
  output logic [MAC_W-1:0]  arp_mac_dout,
  output logic              arp_mac_dout_en,
  output logic              arp_del_dout_en,
  output logic [IP_W-1:0]   arp_req_ip,
  output logic [PORT_W-1:0] arp_req_port,
  output logic              arp_req_en,
  input  logic [IP_W-1:0]   arp_rep_ip,
  input  logic [MAC_W-1:0]  arp_rep_mac,
  input  logic [PORT_W-1:0] arp_rep_port,
  input  logic              arp_rep_en,
  input  logic              arp_flush,
  output logic              arp_busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int RET_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

  logic [2:0]        state;
  logic [IP_W-1:0]   key_ip;
  logic [PORT_W-1:0] key_port;
  logic              snoop;
  logic [MAC_W-1:0]  snoop_mac;
  logic [RET_W-1:0]  retry_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              cam_hit;
  logic [MAC_W-1:0]  cam_mac;
  logic              rep_key_match;

  arp_cam #(
    .ENTRIES  (ENTRIES),
    .NUM_PORTS(NUM_PORTS)
  ) u_cam (
    .clk_net (clk_net),
    .rst_n   (rst_n),
    .key_ip  (key_ip),
    .key_port(key_port),
    .hit     (cam_hit),
    .hit_mac (cam_mac),
    .rep_ip  (arp_rep_ip),
    .rep_port(arp_rep_port),
    .rep_mac (arp_rep_mac),
    .rep_en  (arp_rep_en),
    .flush   (arp_flush)
  );

  assign rep_key_match = arp_rep_en && (arp_rep_ip == key_ip) && (arp_rep_port == key_port);
  assign arp_busy      = (state != ST_IDLE);

  always_ff @(posedge clk_net) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      key_ip          <= '0;
      key_port        <= '0;
      snoop           <= 1'b0;
      snoop_mac       <= '0;
      retry_cnt       <= '0;
      tmo_cnt         <= '0;
      arp_mac_dout    <= '0;
      arp_mac_dout_en <= 1'b0;
      arp_del_dout_en <= 1'b0;
      arp_req_ip      <= '0;
      arp_req_port    <= '0;
      arp_req_en      <= 1'b0;
    end else begin
      arp_mac_dout_en <= 1'b0;
      arp_del_dout_en <= 1'b0;
      arp_req_en      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arp_din_en) begin
            key_ip   <= arp_ip_din;
            key_port <= arp_port_num_din;
            snoop    <= 1'b0;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (rep_key_match) begin
            snoop     <= 1'b1;
            snoop_mac <= arp_rep_mac;
          end
          state <= ST_DECIDE;
        end
        // The freshest source wins: a reply arriving now, then one snooped during LOOKUP,
        // then the table entry, which was compared before those replies landed.
        ST_DECIDE: begin
          if (!port_ok(key_port, NUM_PORTS)) begin
            arp_del_dout_en <= 1'b1;
            state           <= ST_IDLE;
          end else if (rep_key_match) begin
            arp_mac_dout    <= arp_rep_mac;
            arp_mac_dout_en <= 1'b1;
            state           <= ST_IDLE;
          end else if (snoop) begin
            arp_mac_dout    <= snoop_mac;
            arp_mac_dout_en <= 1'b1;
            state           <= ST_IDLE;
          end else if (cam_hit) begin
            arp_mac_dout    <= cam_mac;
            arp_mac_dout_en <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            retry_cnt    <= '0;
            arp_req_en   <= 1'b1;
            arp_req_ip   <= key_ip;
            arp_req_port <= key_port;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rep_key_match) begin
            arp_mac_dout    <= arp_rep_mac;
            arp_mac_dout_en <= 1'b1;
            state           <= ST_IDLE;
          end else if (tmo_cnt == '0) begin
            if (retry_cnt < RET_W'(RETRIES)) begin
              retry_cnt    <= retry_cnt + 1'b1;
              arp_req_en   <= 1'b1;
              arp_req_ip   <= key_ip;
              arp_req_port <= key_port;
              state        <= ST_REQ;
            end else begin
              arp_del_dout_en <= 1'b1;
              state           <= ST_IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_lookup_ctrl.sv
// Scoreboard bench for arp_lookup_ctrl: stimulus queues expected mac/del/req pulses with
// their cycle, an independent negedge monitor pops and compares them.
module tb_arp_lookup_ctrl;

  localparam int TMO = 100;
  localparam logic [2:0] K_MAC = 3'b100;
  localparam logic [2:0] K_DEL = 3'b010;
  localparam logic [2:0] K_REQ = 3'b001;

  logic        clk_net = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] arp_ip_din = '0;
  logic [3:0]  arp_port_num_din = '0;
  logic        arp_din_en = 1'b0;
  logic [47:0] arp_mac_dout;
  logic        arp_mac_dout_en;
  logic        arp_del_dout_en;
  logic [31:0] arp_req_ip;
  logic [3:0]  arp_req_port;
  logic        arp_req_en;
  logic [31:0] arp_rep_ip = '0;
  logic [47:0] arp_rep_mac = '0;
  logic [3:0]  arp_rep_port = '0;
  logic        arp_rep_en = 1'b0;
  logic        arp_flush = 1'b0;
  logic        arp_busy;

  typedef struct {
    logic [2:0]  kind;
    int          cyc;
    logic [47:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   c;

  arp_lookup_ctrl #(
    .ENTRIES       (16),
    .NUM_PORTS     (8),
    .TIMEOUT_CYCLES(TMO),
    .RETRIES       (2)
  ) dut (
    .clk_net         (clk_net),
    .rst_n           (rst_n),
    .arp_ip_din      (arp_ip_din),
    .arp_port_num_din(arp_port_num_din),
    .arp_din_en      (arp_din_en),
    .arp_mac_dout    (arp_mac_dout),
    .arp_mac_dout_en (arp_mac_dout_en),
    .arp_del_dout_en (arp_del_dout_en),
    .arp_req_ip      (arp_req_ip),
    .arp_req_port    (arp_req_port),
    .arp_req_en      (arp_req_en),
    .arp_rep_ip      (arp_rep_ip),
    .arp_rep_mac     (arp_rep_mac),
    .arp_rep_port    (arp_rep_port),
    .arp_rep_en      (arp_rep_en),
    .arp_flush       (arp_flush),
    .arp_busy        (arp_busy)
  );

  always #5 clk_net = ~clk_net;

  always @(posedge clk_net) cyc <= cyc + 1;

  task automatic push_exp(input logic [2:0] kind, input int at, input logic [47:0] data);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance n cycles; single-cycle strobes drop after the first edge.
  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clk_net);
      #1;
      arp_din_en = 1'b0;
      arp_rep_en = 1'b0;
      arp_flush  = 1'b0;
    end
  endtask

  task automatic set_query(input logic [31:0] ip, input logic [3:0] port);
    arp_ip_din       = ip;
    arp_port_num_din = port;
    arp_din_en       = 1'b1;
  endtask

  task automatic set_reply(input logic [31:0] ip, input logic [3:0] port, input logic [47:0] mac);
    arp_rep_ip   = ip;
    arp_rep_port = port;
    arp_rep_mac  = mac;
    arp_rep_en   = 1'b1;
  endtask

  // Monitor: every pulse must match the head of the queue in kind, cycle and data.
  always @(negedge clk_net) begin
    logic [2:0]  act_kind;
    logic [47:0] act_data;
    exp_t        e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missing_event: got none, expected kind=%b at cycle %0d", e.kind, e.cyc);
    end
    act_kind = {arp_mac_dout_en, arp_del_dout_en, arp_req_en};
    act_data = arp_req_en ? {12'h000, arp_req_ip, arp_req_port} :
               arp_mac_dout_en ? arp_mac_dout : 48'h0;
    if (act_kind != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_event: got kind=%b at cycle %0d, expected none", act_kind, cyc);
      end else begin
        e = exp_q.pop_front();
        if (act_kind != e.kind || cyc != e.cyc) begin
          failures++;
          $display("[TB] FAIL event: got kind=%b cycle=%0d, expected kind=%b cycle=%0d",
                   act_kind, cyc, e.kind, e.cyc);
        end
        checks++;
        if (act_data !== e.data) begin
          failures++;
          $display("[TB] FAIL event_data: got %h, expected %h (cycle %0d)", act_data, e.data, cyc);
        end
      end
    end
  end

  initial begin
    apply_stimulus(3);
    check_output("rst_busy", arp_busy, 0);
    check_output("rst_mac_en", arp_mac_dout_en, 0);
    check_output("rst_del_en", arp_del_dout_en, 0);
    check_output("rst_req_en", arp_req_en, 0);
    check_output("rst_mac_dout", arp_mac_dout, 0);
    check_output("rst_req_ip", arp_req_ip, 0);
    rst_n = 1'b1;
    apply_stimulus(2);

    // Miss -> request at +3, reply 10 cycles after the request -> mac next cycle.
    c = cyc;
    set_query(32'hC0A80001, 4'd3);
    push_exp(K_REQ, c + 3, {12'h000, 32'hC0A80001, 4'd3});
    apply_stimulus(1);
    check_output("busy_lookup", arp_busy, 1);
    apply_stimulus(12);
    set_reply(32'hC0A80001, 4'd3, 48'h001122334455);
    push_exp(K_MAC, c + 14, 48'h001122334455);
    apply_stimulus(3);
    check_output("idle_after_reply", arp_busy, 0);

    // Same query now hits the learned entry.
    c = cyc;
    set_query(32'hC0A80001, 4'd3);
    push_exp(K_MAC, c + 3, 48'h001122334455);
    apply_stimulus(5);

    // No replies: three requests 101 cycles apart, then delete after the last timeout.
    c = cyc;
    set_query(32'h0A000009, 4'd1);
    push_exp(K_REQ, c + 3,   {12'h000, 32'h0A000009, 4'd1});
    push_exp(K_REQ, c + 104, {12'h000, 32'h0A000009, 4'd1});
    push_exp(K_REQ, c + 205, {12'h000, 32'h0A000009, 4'd1});
    push_exp(K_DEL, c + 306, 48'h0);
    apply_stimulus(310);
    check_output("idle_after_del", arp_busy, 0);

    // 17 learns into 16 entries: the oldest of the batch (i=0) is overwritten.
    for (int i = 0; i < 17; i++) begin
      set_reply(32'h0A000000 + i, 4'd2, 48'h0000AA000000 + 48'(i));
      apply_stimulus(1);
    end
    apply_stimulus(2);
    c = cyc;
    set_query(32'h0A000000, 4'd2);
    push_exp(K_REQ, c + 3, {12'h000, 32'h0A000000, 4'd2});
    apply_stimulus(10);
    set_reply(32'h0A000000, 4'd2, 48'h0000AA0000FF);
    push_exp(K_MAC, c + 11, 48'h0000AA0000FF);
    apply_stimulus(3);
    c = cyc;
    set_query(32'h0A000010, 4'd2);
    push_exp(K_MAC, c + 3, 48'h0000AA000010);
    apply_stimulus(5);

    // Reply in the DECIDE cycle, then in the LOOKUP cycle: answered without a request.
    c = cyc;
    set_query(32'h0B000001, 4'd4);
    push_exp(K_MAC, c + 3, 48'h0B0B0B0B0B01);
    apply_stimulus(2);
    set_reply(32'h0B000001, 4'd4, 48'h0B0B0B0B0B01);
    apply_stimulus(4);
    c = cyc;
    set_query(32'h0B000002, 4'd5);
    push_exp(K_MAC, c + 3, 48'h0B0B0B0B0B02);
    apply_stimulus(1);
    set_reply(32'h0B000002, 4'd5, 48'h0B0B0B0B0B02);
    apply_stimulus(4);

    // Out-of-range ports are deleted immediately.
    c = cyc;
    set_query(32'h01020304, 4'd0);
    push_exp(K_DEL, c + 3, 48'h0);
    apply_stimulus(5);
    c = cyc;
    set_query(32'h01020304, 4'd9);
    push_exp(K_DEL, c + 3, 48'h0);
    apply_stimulus(5);

    // Queries while busy are dropped.
    c = cyc;
    set_query(32'h0A000010, 4'd2);
    push_exp(K_MAC, c + 3, 48'h0000AA000010);
    apply_stimulus(1);
    set_query(32'h01020304, 4'd0);
    apply_stimulus(1);
    set_query(32'h01020304, 4'd0);
    apply_stimulus(6);

    // Reset during WAIT aborts silently and clears the table.
    c = cyc;
    set_query(32'h0C000001, 4'd6);
    push_exp(K_REQ, c + 3, {12'h000, 32'h0C000001, 4'd6});
    apply_stimulus(8);
    rst_n = 1'b0;
    apply_stimulus(1);
    check_output("midrst_busy", arp_busy, 0);
    check_output("midrst_req_en", arp_req_en, 0);
    check_output("midrst_mac_en", arp_mac_dout_en, 0);
    check_output("midrst_del_en", arp_del_dout_en, 0);
    check_output("midrst_mac_dout", arp_mac_dout, 0);
    rst_n = 1'b1;
    apply_stimulus(2);
    c = cyc;
    set_query(32'h0A000010, 4'd2);
    push_exp(K_REQ, c + 3, {12'h000, 32'h0A000010, 4'd2});
    apply_stimulus(6);
    // Reply with a simultaneous flush: answers the query but is not stored.
    set_reply(32'h0A000010, 4'd2, 48'h0000AA000010);
    arp_flush = 1'b1;
    push_exp(K_MAC, c + 7, 48'h0000AA000010);
    apply_stimulus(3);
    c = cyc;
    set_query(32'h0A000010, 4'd2);
    push_exp(K_REQ, c + 3, {12'h000, 32'h0A000010, 4'd2});
    apply_stimulus(5);
    set_reply(32'h0A000010, 4'd2, 48'h0000BB000010);
    push_exp(K_MAC, c + 6, 48'h0000BB000010);
    apply_stimulus(4);
    c = cyc;
    set_query(32'h0A000010, 4'd2);
    push_exp(K_MAC, c + 3, 48'h0000BB000010);
    apply_stimulus(6);

    check_output("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
